// File: rtl/div_share_sched.sv
// div_share_sched: round-robin sharing of one pipelined divider among NREQ requesters; `DIV_FIXUP_EN adds div-by-zero/overflow fixups
module div_share_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  parameter int PIPELINE = 4,
  parameter int SIGNED = 0,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_numer,
  input  logic [NREQ*WIDTH-1:0] req_denom,
  output logic                  div_clken,
  output logic [WIDTH-1:0]      div_numer,
  output logic [WIDTH-1:0]      div_denom,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder
`ifdef DIV_FIXUP_EN
  ,
  output logic                  rsp_divzero
`endif
);
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
`ifdef DIV_FIXUP_EN
    logic             dz;
    logic             ov;
    logic [WIDTH-1:0] numer;
`endif
  } tag_t;
`ifdef DIV_FIXUP_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif
  if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
    $error("SIGNED must be 0 or 1");
  end
  logic advance, accept, any, hi, lo, load;
  logic [IDW-1:0] hi_id, lo_id, grant_id, last_grant_q, last_grant_d;
  tag_t tag_in, tag_out;
  logic rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, fix_q, fix_r;
`ifdef DIV_FIXUP_EN
  logic dz_q, dz_d;
`endif
  assign advance   = !rsp_valid_q || rsp_ready;
  assign div_clken = advance;
  // round-robin: lowest valid id above last_grant wins, else lowest valid at or below it
  always_comb begin
    hi = 1'b0;
    lo = 1'b0;
    hi_id = '0;
    lo_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && IDW'(i) > last_grant_q) begin hi = 1'b1; hi_id = IDW'(i); end
      if (req_valid[i] && IDW'(i) <= last_grant_q) begin lo = 1'b1; lo_id = IDW'(i); end
    end
  end
  assign any          = hi || lo;
  assign grant_id     = hi ? hi_id : lo_id;
  assign accept       = advance && any && !aclr;
  assign req_ready    = accept ? NREQ'(1) << grant_id : '0;
  assign div_numer    = any ? req_numer[int'(grant_id)*WIDTH +: WIDTH] : '0;
  assign div_denom    = any ? req_denom[int'(grant_id)*WIDTH +: WIDTH] : '0;
  assign last_grant_d = accept ? grant_id : last_grant_q;
  // tag entering the pipe alongside the operands
  always_comb begin
    tag_in = '0;
    tag_in.v = accept;
    tag_in.id = grant_id;
`ifdef DIV_FIXUP_EN
    tag_in.dz = div_denom == '0;
    tag_in.ov = SIGNED != 0 && div_numer == MIN_VAL && div_denom == '1;
    tag_in.numer = div_numer;
`endif
  end
  if (PIPELINE == 0) begin : g_nopipe
    assign tag_out = tag_in;
  end else begin : g_pipe
    tag_t pipe_q [PIPELINE];
    // tag shift register advancing in lockstep with the divider clock enable
    always_ff @(posedge clock or posedge aclr)
      if (aclr) for (int i = 0; i < PIPELINE; i++) pipe_q[i] <= '0;
      else if (advance) begin
        pipe_q[0] <= tag_in;
        for (int i = 1; i < PIPELINE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    assign tag_out = pipe_q[PIPELINE-1];
  end
`ifdef DIV_FIXUP_EN
  assign fix_q = tag_out.dz ? '1 : tag_out.ov ? MIN_VAL : div_quotient;
  assign fix_r = tag_out.dz ? tag_out.numer : tag_out.ov ? '0 : div_remainder;
`else
  assign fix_q = div_quotient;
  assign fix_r = div_remainder;
`endif
  assign load = advance && tag_out.v;
  // response register next state: load on exit, clear when advancing empty, else hold
  always_comb begin
    rsp_valid_d = advance ? tag_out.v : rsp_valid_q;
    rsp_id_d = load ? tag_out.id : rsp_id_q;
    quo_d = load ? fix_q : quo_q;
    rem_d = load ? fix_r : rem_q;
`ifdef DIV_FIXUP_EN
    dz_d = load ? tag_out.dz : dz_q;
`endif
  end
  // state registers
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      last_grant_q <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
`ifdef DIV_FIXUP_EN
      dz_q <= 1'b0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
`ifdef DIV_FIXUP_EN
      dz_q <= dz_d;
`endif
    end
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
`ifdef DIV_FIXUP_EN
  assign rsp_divzero   = dz_q;
`endif
endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: directed bench for div_share_sched with behavioural dividers (PIPELINE=4 unsigned, PIPELINE=0 signed)
module tb_div_share_sched;
  logic clock = 1'b0;
  logic aclr = 1'b1;
  always #5 clock = ~clock;
  int tests = 0;
  int fails = 0;
  logic [1:0] req_valid, req_ready, req_valid_s, req_ready_s;
  logic [63:0] req_numer, req_denom, req_numer_s, req_denom_s;
  logic div_clken, div_clken_s, rsp_valid, rsp_valid_s, rsp_ready, rsp_ready_s;
  logic [31:0] div_numer, div_denom, div_quotient, div_remainder;
  logic [31:0] div_numer_s, div_denom_s, div_quotient_s, div_remainder_s;
  logic [0:0] rsp_id, rsp_id_s;
  logic [31:0] rsp_quotient, rsp_remainder, rsp_quotient_s, rsp_remainder_s;
`ifdef DIV_FIXUP_EN
  logic rsp_divzero, rsp_divzero_s;
`endif

  div_share_sched #(.WIDTH(32), .NREQ(2), .PIPELINE(4), .SIGNED(0)) dut (
    .clock(clock), .aclr(aclr), .req_valid(req_valid), .req_ready(req_ready),
    .req_numer(req_numer), .req_denom(req_denom), .div_clken(div_clken),
    .div_numer(div_numer), .div_denom(div_denom), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder)
`ifdef DIV_FIXUP_EN
    , .rsp_divzero(rsp_divzero)
`endif
  );

  div_share_sched #(.WIDTH(32), .NREQ(2), .PIPELINE(0), .SIGNED(1)) dut_s (
    .clock(clock), .aclr(aclr), .req_valid(req_valid_s), .req_ready(req_ready_s),
    .req_numer(req_numer_s), .req_denom(req_denom_s), .div_clken(div_clken_s),
    .div_numer(div_numer_s), .div_denom(div_denom_s), .div_quotient(div_quotient_s),
    .div_remainder(div_remainder_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready_s),
    .rsp_id(rsp_id_s), .rsp_quotient(rsp_quotient_s), .rsp_remainder(rsp_remainder_s)
`ifdef DIV_FIXUP_EN
    , .rsp_divzero(rsp_divzero_s)
`endif
  );

  // raw divider behaviour, with recognisable junk for the cases the scheduler may fix up
  function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
    if (d == 0) return {32'hDEADBEEF, ~n};
    return {n / d, n % d};
  endfunction
  function automatic logic [63:0] sdiv(input logic [31:0] n, input logic [31:0] d);
    if (d == 0) return {32'hDEADBEEF, ~n};
    if (n == 32'h80000000 && d == 32'hFFFFFFFF) return {32'h0BAD0BAD, 32'h00000BAD};
    return {32'($signed(n) / $signed(d)), 32'($signed(n) % $signed(d))};
  endfunction

  logic [63:0] mp [4];
  always @(posedge clock or posedge aclr)
    if (aclr) for (int i = 0; i < 4; i++) mp[i] <= '0;
    else if (div_clken) begin
      mp[0] <= udiv(div_numer, div_denom);
      for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
    end
  assign {div_quotient, div_remainder} = mp[3];
  assign {div_quotient_s, div_remainder_s} = sdiv(div_numer_s, div_denom_s);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    req_valid = 2'b11;
    req_numer = {32'd9, 32'd8};
    req_denom = {32'd3, 32'd2};
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    tests++; if (rsp_quotient !== 32'd0) begin fails++; $display("FAIL reset_quot: got %0h want 0", rsp_quotient); end
    tests++; if (rsp_remainder !== 32'd0) begin fails++; $display("FAIL reset_rem: got %0h want 0", rsp_remainder); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
`ifdef DIV_FIXUP_EN
    tests++; if (rsp_divzero !== 1'b0) begin fails++; $display("FAIL reset_dz: got %0b want 0", rsp_divzero); end
`endif
    aclr = 1'b0;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_single();
    req_numer[31:0] = 32'd100;
    req_denom[31:0] = 32'd7;
    req_valid = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      tests++; if (rsp_valid !== (k == 5)) begin fails++; $display("FAIL single_valid c%0d: got %0b want %0b", k, rsp_valid, k == 5); end
      if (k == 5) begin
        tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        tests++; if (rsp_quotient !== 32'd14) begin fails++; $display("FAIL single_quot: got %0d want 14", rsp_quotient); end
        tests++; if (rsp_remainder !== 32'd2) begin fails++; $display("FAIL single_rem: got %0d want 2", rsp_remainder); end
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [1:0] er;
    logic ei;
    req_numer = {32'd47, 32'd50};
    req_denom = {32'd4, 32'd5};
    for (int k = 0; k <= 9; k++) begin
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      er = (k >= 4) ? 2'b00 : (k % 2 == 0) ? 2'b10 : 2'b01;
      tests++; if (req_ready !== er) begin fails++; $display("FAIL cont_ready c%0d: got %b want %b", k, req_ready, er); end
      tests++; if (rsp_valid !== (k >= 5 && k <= 8)) begin fails++; $display("FAIL cont_valid c%0d: got %0b", k, rsp_valid); end
      if (k >= 5 && k <= 8) begin
        ei = ((k - 5) % 2 == 0);
        tests++; if (rsp_id !== ei) begin fails++; $display("FAIL cont_id c%0d: got %0d want %0d", k, rsp_id, ei); end
        tests++; if (rsp_quotient !== (ei ? 32'd11 : 32'd10)) begin fails++; $display("FAIL cont_quot c%0d: got %0d", k, rsp_quotient); end
        tests++; if (rsp_remainder !== (ei ? 32'd3 : 32'd0)) begin fails++; $display("FAIL cont_rem c%0d: got %0d", k, rsp_remainder); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int idx;
    req_denom[31:0] = 32'd9;
    for (int k = 0; k <= 12; k++) begin
      req_valid = (k < 4 || (k >= 5 && k <= 7)) ? 2'b01 : 2'b00;
      if (k < 4) req_numer[31:0] = 32'(100 * (k + 1));
      rsp_ready = !(k >= 5 && k <= 7);
      #1;
      tests++; if (req_ready !== ((k < 4) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL bp_ready c%0d: got %b", k, req_ready); end
      tests++; if (div_clken !== !(k >= 5 && k <= 7)) begin fails++; $display("FAIL bp_clken c%0d: got %0b", k, div_clken); end
      tests++; if (rsp_valid !== (k >= 5 && k <= 11)) begin fails++; $display("FAIL bp_valid c%0d: got %0b", k, rsp_valid); end
      if (k >= 5 && k <= 11) begin
        idx = (k <= 8) ? 0 : k - 8;
        tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL bp_id c%0d: got %0d want 0", k, rsp_id); end
        tests++; if (rsp_quotient !== 32'(11 * (idx + 1))) begin fails++; $display("FAIL bp_quot c%0d: got %0d want %0d", k, rsp_quotient, 11 * (idx + 1)); end
        tests++; if (rsp_remainder !== 32'(idx + 1)) begin fails++; $display("FAIL bp_rem c%0d: got %0d want %0d", k, rsp_remainder, idx + 1); end
      end
      step();
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_divzero();
    req_numer[63:32] = 32'd55;
    req_denom[63:32] = 32'd0;
    req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL dz_ready: got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    for (int k = 1; k <= 4; k++) step();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL dz_valid: got %0b want 1", rsp_valid); end
    tests++; if (rsp_id !== 1'b1) begin fails++; $display("FAIL dz_id: got %0d want 1", rsp_id); end
`ifdef DIV_FIXUP_EN
    tests++; if (rsp_quotient !== 32'hFFFFFFFF) begin fails++; $display("FAIL dz_quot: got %0h want ffffffff", rsp_quotient); end
    tests++; if (rsp_remainder !== 32'd55) begin fails++; $display("FAIL dz_rem: got %0d want 55", rsp_remainder); end
    tests++; if (rsp_divzero !== 1'b1) begin fails++; $display("FAIL dz_flag: got %0b want 1", rsp_divzero); end
`else
    tests++; if (rsp_quotient !== 32'hDEADBEEF) begin fails++; $display("FAIL dz_raw_quot: got %0h want deadbeef", rsp_quotient); end
    tests++; if (rsp_remainder !== ~32'd55) begin fails++; $display("FAIL dz_raw_rem: got %0h want %0h", rsp_remainder, ~32'd55); end
`endif
    step();
  endtask

  task automatic test_signed();
    req_numer_s[31:0] = 32'hFFFFFFF9;
    req_denom_s[31:0] = 32'd2;
    req_valid_s = 2'b01;
    #1;
    tests++; if (req_ready_s !== 2'b01) begin fails++; $display("FAIL sgn_ready: got %b want 01", req_ready_s); end
    tests++; if (div_clken_s !== 1'b1) begin fails++; $display("FAIL sgn_clken: got %0b want 1", div_clken_s); end
    step();
    req_valid_s = 2'b00;
    tests++; if (rsp_valid_s !== 1'b1) begin fails++; $display("FAIL sgn_valid: got %0b want 1", rsp_valid_s); end
    tests++; if (rsp_quotient_s !== 32'hFFFFFFFD) begin fails++; $display("FAIL sgn_quot: got %0h want fffffffd", rsp_quotient_s); end
    tests++; if (rsp_remainder_s !== 32'hFFFFFFFF) begin fails++; $display("FAIL sgn_rem: got %0h want ffffffff", rsp_remainder_s); end
    req_numer_s[31:0] = 32'h80000000;
    req_denom_s[31:0] = 32'hFFFFFFFF;
    req_valid_s = 2'b01;
    step();
    req_valid_s = 2'b00;
    tests++; if (rsp_valid_s !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %0b want 1", rsp_valid_s); end
`ifdef DIV_FIXUP_EN
    tests++; if (rsp_quotient_s !== 32'h80000000) begin fails++; $display("FAIL ovf_quot: got %0h want 80000000", rsp_quotient_s); end
    tests++; if (rsp_remainder_s !== 32'd0) begin fails++; $display("FAIL ovf_rem: got %0h want 0", rsp_remainder_s); end
    tests++; if (rsp_divzero_s !== 1'b0) begin fails++; $display("FAIL ovf_dz: got %0b want 0", rsp_divzero_s); end
`else
    tests++; if (rsp_quotient_s !== 32'h0BAD0BAD) begin fails++; $display("FAIL ovf_raw_quot: got %0h want 0bad0bad", rsp_quotient_s); end
    tests++; if (rsp_remainder_s !== 32'h00000BAD) begin fails++; $display("FAIL ovf_raw_rem: got %0h want bad", rsp_remainder_s); end
`endif
    step();
    tests++; if (rsp_valid_s !== 1'b0) begin fails++; $display("FAIL sgn_drain: got %0b want 0", rsp_valid_s); end
  endtask

  task automatic test_reset_midflight();
    req_numer[31:0] = 32'd81;
    req_denom[31:0] = 32'd9;
    for (int k = 0; k <= 4; k++) begin
      req_valid = (k < 3) ? 2'b01 : 2'b00;
      step();
    end
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %0b want 1", rsp_valid); end
    aclr = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_clear: got %0b want 0", rsp_valid); end
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL mid_ready_in_reset: got %b want 00", req_ready); end
    step();
    step();
    aclr = 1'b0;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_first_grant: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    for (int j = 1; j <= 7; j++) begin
      tests++; if (rsp_valid !== (j == 5)) begin fails++; $display("FAIL mid_valid c%0d: got %0b want %0b", j, rsp_valid, j == 5); end
      if (j == 5) begin
        tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL mid_id: got %0d want 0", rsp_id); end
        tests++; if (rsp_quotient !== 32'd9) begin fails++; $display("FAIL mid_quot: got %0d want 9", rsp_quotient); end
        tests++; if (rsp_remainder !== 32'd0) begin fails++; $display("FAIL mid_rem: got %0d want 0", rsp_remainder); end
      end
      step();
    end
  endtask

  initial begin
    req_valid = 2'b00;
    req_numer = '0;
    req_denom = '0;
    rsp_ready = 1'b1;
    req_valid_s = 2'b00;
    req_numer_s = '0;
    req_denom_s = '0;
    rsp_ready_s = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_divzero();
    test_signed();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
